// File: rtl/divider_pipe_hs.sv
// Pipelined unsigned restoring divider (2W / W) with valid/ready handshake and tag passthrough.
// Define DIVIDER_PIPE_SIGNED_EN to add the sgn port for two's complement division.
module divider_pipe_hs #(
   parameter int unsigned W      = 32,
   parameter int unsigned NSTAGE = 2,
   parameter int unsigned TW     = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*W-1:0]  x,
   input  logic [W-1:0]    d,
   input  logic [TW-1:0]   in_tag,
`ifdef DIVIDER_PIPE_SIGNED_EN
   input  logic            sgn,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    q,
   output logic [W-1:0]    r,
   output logic            dz,
   output logic            ovf,
   output logic [TW-1:0]   out_tag
);

   localparam int unsigned S = W / NSTAGE;
   localparam int unsigned L = NSTAGE - 1;

   logic advance;

   // Remaining dividend bits and quotient bits share one shift register:
   // each trial shifts a dividend bit out of the top and a quotient bit in at the bottom.
   logic          v_q   [NSTAGE];
   logic [W-1:0]  rem_q [NSTAGE];
   logic [W-1:0]  xq_q  [NSTAGE];
   logic [W-1:0]  d_q   [NSTAGE];
   logic [W-1:0]  xr_q  [NSTAGE];
   logic [TW-1:0] tag_q [NSTAGE];
   logic          dz_q  [NSTAGE];
   logic          ovf_q [NSTAGE];
`ifdef DIVIDER_PIPE_SIGNED_EN
   logic          sgn_q  [NSTAGE];
   logic          qneg_q [NSTAGE];
   logic          rneg_q [NSTAGE];
   logic          xneg, dneg;
`endif

   logic [2*W-1:0] xm;
   logic [W-1:0]   dm;
   logic           dz0, ovf0;

   assign advance  = !v_q[L] || out_ready;
   assign in_ready = advance;

`ifdef DIVIDER_PIPE_SIGNED_EN
   always_comb begin
      xneg = sgn & x[2*W-1];
      dneg = sgn & d[W-1];
      xm   = xneg ? -x : x;
      dm   = dneg ? -d : d;
   end
`else
   always_comb begin
      xm = x;
      dm = d;
   end
`endif

   always_comb begin
      dz0  = (d == '0);
      ovf0 = !dz0 && (xm[2*W-1:W] >= dm);
   end

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      logic [W-1:0]  rem_i, xq_i, d_i, xr_i, rem_o, xq_o;
      logic [TW-1:0] tag_i;
      logic          v_i, dz_i, ovf_i;
`ifdef DIVIDER_PIPE_SIGNED_EN
      logic          sgn_i, qneg_i, rneg_i;
`endif

      if (k == 0) begin : g_first
         always_comb begin
            v_i   = in_valid;
            rem_i = xm[2*W-1:W];
            xq_i  = xm[W-1:0];
            d_i   = dm;
            xr_i  = x[W-1:0];
            tag_i = in_tag;
            dz_i  = dz0;
            ovf_i = ovf0;
`ifdef DIVIDER_PIPE_SIGNED_EN
            sgn_i  = sgn;
            qneg_i = xneg ^ dneg;
            rneg_i = xneg;
`endif
         end
      end else begin : g_next
         always_comb begin
            v_i   = v_q[k-1];
            rem_i = rem_q[k-1];
            xq_i  = xq_q[k-1];
            d_i   = d_q[k-1];
            xr_i  = xr_q[k-1];
            tag_i = tag_q[k-1];
            dz_i  = dz_q[k-1];
            ovf_i = ovf_q[k-1];
`ifdef DIVIDER_PIPE_SIGNED_EN
            sgn_i  = sgn_q[k-1];
            qneg_i = qneg_q[k-1];
            rneg_i = rneg_q[k-1];
`endif
         end
      end

      always_comb begin
         logic [W:0] t;
         logic       ge;
         t     = '0;
         ge    = 1'b0;
         rem_o = rem_i;
         xq_o  = xq_i;
         for (int unsigned i = 0; i < S; i++) begin
            t  = {rem_o, xq_o[W-1]};
            ge = (t >= {1'b0, d_i});
            if (ge) t = t - {1'b0, d_i};
            xq_o  = {xq_o[W-2:0], ge};
            rem_o = t[W-1:0];
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            v_q[k]   <= 1'b0;
            rem_q[k] <= '0;
            xq_q[k]  <= '0;
            d_q[k]   <= '0;
            xr_q[k]  <= '0;
            tag_q[k] <= '0;
            dz_q[k]  <= 1'b0;
            ovf_q[k] <= 1'b0;
`ifdef DIVIDER_PIPE_SIGNED_EN
            sgn_q[k]  <= 1'b0;
            qneg_q[k] <= 1'b0;
            rneg_q[k] <= 1'b0;
`endif
         end else if (advance) begin
            v_q[k]   <= v_i;
            rem_q[k] <= rem_o;
            xq_q[k]  <= xq_o;
            d_q[k]   <= d_i;
            xr_q[k]  <= xr_i;
            tag_q[k] <= tag_i;
            dz_q[k]  <= dz_i;
            ovf_q[k] <= ovf_i;
`ifdef DIVIDER_PIPE_SIGNED_EN
            sgn_q[k]  <= sgn_i;
            qneg_q[k] <= qneg_i;
            rneg_q[k] <= rneg_i;
`endif
         end
      end
   end

   logic [W-1:0] q_res, r_res;
   logic         ovf_o;

`ifdef DIVIDER_PIPE_SIGNED_EN
   // Magnitude quotient must fit 2^(W-1)-1 when positive, 2^(W-1) when negative.
   always_comb begin
      q_res = qneg_q[L] ? -xq_q[L] : xq_q[L];
      r_res = rneg_q[L] ? -rem_q[L] : rem_q[L];
      ovf_o = ovf_q[L] | (sgn_q[L] & ~dz_q[L] &
              (qneg_q[L] ? (xq_q[L] > {1'b1, {(W-1){1'b0}}}) : xq_q[L][W-1]));
   end
`else
   always_comb begin
      q_res = xq_q[L];
      r_res = rem_q[L];
      ovf_o = ovf_q[L];
   end
`endif

   always_comb begin
      out_valid = v_q[L];
      out_tag   = tag_q[L];
      dz        = dz_q[L];
      ovf       = ovf_o;
      q         = (dz_q[L] | ovf_o) ? '1 : q_res;
      r         = (dz_q[L] | ovf_o) ? xr_q[L] : r_res;
   end

endmodule
